// File: rtl/ramctrl_pkg.sv
// Shared types and helpers for the line-oriented RAM controller.
// Pure definitions: no latency, no flow control.
package ramctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DONE, ST_ERR} state_t;

  // Ceiling log2 with a floor of 1 so single-entry indices still get a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Low bit of a beat's word within a line; beat 0 is the most significant word.
  function automatic int beat_lo(input int line_w, input int ram_w, input int beat);
    return line_w - ram_w * (beat + 1);
  endfunction

endpackage

// File: rtl/ramctrl_mc_rr_arbiter.sv
// Round-robin pick of the first active request at or above ptr, wrapping mod NCH.
// Purely combinational, zero latency; no backpressure (the caller samples when free).
module rr_arbiter
  import ramctrl_pkg::*;
#(
  parameter int NCH = 2,
  localparam int PW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  gnt,
  output logic           vld
);

  logic [2*NCH-1:0] rot;

  assign rot = {req, req} >> ptr;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!vld && rot[i]) begin
        vld = 1'b1;
        gnt = PW'((int'(ptr) + i) % NCH);
      end
    end
  end

endmodule

// File: rtl/ramctrl_mc.sv
// Arbitrates NCH line requests onto one RAM port, BEATS words per line, MSB word first.
// Min stb-to-ack BEATS+2 cycles; RAM stalls via ram_ack, bounded per beat by a TMO watchdog.
module ramctrl_mc
  import ramctrl_pkg::*;
#(
  parameter int          NCH   = 2,
  parameter int          AW    = 25,
  parameter int          BEATS = 4,
  parameter int          RAM_W = 32,
  parameter logic [63:0] LIMIT = 64'd1 << 23,
  parameter int          TMO   = 255,
  localparam int         BW     = clog2(BEATS),
  localparam int         LINE_W = BEATS * RAM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        ch_stb,
  input  logic [NCH-1:0]        ch_we,
  input  logic [NCH*AW-1:0]     ch_addr,
  input  logic [NCH*LINE_W-1:0] ch_din,
  output logic [LINE_W-1:0]     ch_dout,
  output logic [NCH-1:0]        ch_ack,
  output logic [NCH-1:0]        ch_timeout,
  output logic                  ram_stb,
  output logic                  ram_we,
  output logic [AW+BW-1:0]      ram_addr,
  output logic [RAM_W-1:0]      ram_wdata,
  input  logic [RAM_W-1:0]      ram_rdata,
  input  logic                  ram_ack
);

  localparam int             PW        = clog2(NCH);
  localparam int             WW        = clog2(TMO + 1);
  localparam logic [WW-1:0]  WD_LAST   = WW'((TMO == 0) ? 0 : TMO - 1);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BEATS - 1);

  state_t              state;
  logic [PW-1:0]       gnt;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       arb_gnt;
  logic                arb_vld;
  logic                we_lat;
  logic [BW-1:0]       beat;
  logic [WW-1:0]       wdog;
  logic [AW-1:0]       req_addr;
  logic [AW-1:0]       cur_addr;
  logic [LINE_W-1:0]   cur_line;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req (ch_stb),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  assign req_addr = ch_addr[int'(arb_gnt)*AW +: AW];
  assign cur_addr = ch_addr[int'(gnt)*AW +: AW];
  assign cur_line = ch_din[int'(gnt)*LINE_W +: LINE_W];

  assign ram_stb    = (state == ST_XFER);
  assign ram_we     = ram_stb & we_lat;
  assign ram_addr   = {cur_addr, beat};
  assign ram_wdata  = cur_line[beat_lo(LINE_W, RAM_W, int'(beat)) +: RAM_W];
  assign ch_ack     = (state == ST_DONE) ? (NCH'(1) << gnt) : '0;
  assign ch_timeout = (state == ST_ERR)  ? (NCH'(1) << gnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      we_lat <= 1'b0;
      beat   <= '0;
      wdog   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt    <= arb_gnt;
            we_lat <= ch_we[arb_gnt];
            beat   <= '0;
            wdog   <= '0;
            // Rejected requests still advance the pointer so a bad master cannot hog the port.
            rr_ptr <= (int'(arb_gnt) == NCH - 1) ? '0 : arb_gnt + 1'b1;
            state  <= (64'(req_addr) < LIMIT) ? ST_XFER : ST_ERR;
          end
        end
        ST_XFER: begin
          if (ram_ack) begin
            wdog <= '0;
            beat <= beat + 1'b1;
            if (beat == BEAT_LAST) state <= ST_DONE;
          end else if (TMO != 0 && wdog == WD_LAST) begin
            state <= ST_ERR;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Line buffer is not reset: contents are only meaningful alongside a read ack.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_XFER && !we_lat && ram_ack)
      ch_dout[beat_lo(LINE_W, RAM_W, int'(beat)) +: RAM_W] <= ram_rdata;
  end

endmodule

// File: tb/tb_ramctrl_mc.sv
// Directed bench for ramctrl_mc: vector table of single-line transfers plus
// hand sequences for alternating grants, ack watchdog and mid-burst reset.
module tb_ramctrl_mc;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   ch_stb, ch_we;
  logic [49:0]  ch_addr;
  logic [255:0] ch_din;
  logic [127:0] ch_dout;
  logic [1:0]   ch_ack, ch_timeout;
  logic         ram_stb, ram_we, ram_ack;
  logic [26:0]  ram_addr;
  logic [31:0]  ram_wdata, ram_rdata;

  ramctrl_mc #(
    .NCH(2), .AW(25), .BEATS(4), .RAM_W(32), .LIMIT(64'd1 << 23), .TMO(8)
  ) dut (
    .clk(clk), .rst(rst), .ch_stb(ch_stb), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_din(ch_din), .ch_dout(ch_dout), .ch_ack(ch_ack), .ch_timeout(ch_timeout),
    .ram_stb(ram_stb), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read as C0DE0000|index; wait_req stall cycles per beat.
  logic [31:0] mem [0:1023];
  bit          written [0:1023];
  logic [58:0] wlog [0:255];
  int          wr_seq = 0;
  int          wcnt = 0;
  int          wait_req = 0;
  int          hold_beat = -1;

  assign ram_ack   = ram_stb && (wcnt >= wait_req) && (int'(ram_addr[1:0]) != hold_beat);
  assign ram_rdata = written[ram_addr[9:0]] ? mem[ram_addr[9:0]] : (32'hC0DE0000 | 32'(ram_addr[9:0]));

  always @(posedge clk) begin
    if (ram_stb && !ram_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (ram_stb && ram_we && ram_ack) begin
      mem[ram_addr[9:0]]     <= ram_wdata;
      written[ram_addr[9:0]] <= 1'b1;
      wlog[wr_seq[7:0]]      <= {ram_addr, ram_wdata};
      wr_seq                 <= wr_seq + 1;
    end
  end

  int ack_cnt = 0, to_cnt = 0, stb_cnt = 0;
  always @(negedge clk) begin
    if (ch_ack != 0)     ack_cnt <= ack_cnt + 1;
    if (ch_timeout != 0) to_cnt  <= to_cnt + 1;
    if (ram_stb)         stb_cnt <= stb_cnt + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    int           ch;
    bit           we;
    logic [24:0]  addr;
    logic [127:0] din;
    int           wt;
    bit           err;
    logic [127:0] exp_dout;
    int           lat;
    int           nstb;
  } vec_t;

  // One request on one channel; lat is the cycle of ack/timeout with the stb cycle as 1.
  task automatic do_req(input vec_t v, output logic [1:0] ack, output logic [1:0] to,
                        output int lat, output logic [127:0] dout, output int nstb);
    int s0;
    bit done;
    wait_req = v.wt;
    @(posedge clk); #1;
    ch_addr[v.ch*25 +: 25] = v.addr;
    ch_din[v.ch*128 +: 128] = v.din;
    ch_we[v.ch]  = v.we;
    ch_stb[v.ch] = 1'b1;
    s0   = stb_cnt;
    lat  = 0;
    done = 1'b0;
    ack  = '0;
    to   = '0;
    dout = '0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (ch_ack != 0 || ch_timeout != 0) begin
        done = 1'b1;
        ack  = ch_ack;
        to   = ch_timeout;
        dout = ch_dout;
      end
    end
    @(posedge clk); #1;
    ch_stb = '0;
    nstb = stb_cnt - s0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_wait[%0d]: got no ack/timeout within 200 cycles, want one", v.ch);
    end
  endtask

  localparam logic [127:0] PAT10 = 128'hC0DE0040_C0DE0041_C0DE0042_C0DE0043;
  localparam logic [127:0] D1234 = 128'h00000001_00000002_00000003_00000004;
  localparam logic [127:0] DBIG  = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: run still active, want finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]   a, t, oh;
    logic [127:0] d, dl;
    logic [58:0]  e;
    int           lat, ns, w0, a0, t0, k, n;
    logic [1:0]   alt_ack [4];
    int           alt_cyc [4];
    logic [127:0] alt_dout [4];
    vec_t         v;

    tbl[0] = '{0, 1'b0, 25'h10,     '0,    0, 1'b0, PAT10, 6,  4};
    tbl[1] = '{1, 1'b1, 25'h20,     D1234, 2, 1'b0, '0,    14, 12};
    tbl[2] = '{1, 1'b0, 25'h20,     '0,    1, 1'b0, D1234, 10, 8};
    tbl[3] = '{0, 1'b1, 25'h7FFFFF, DBIG,  0, 1'b0, '0,    6,  4};
    tbl[4] = '{0, 1'b0, 25'h7FFFFF, '0,    0, 1'b0, DBIG,  6,  4};
    tbl[5] = '{0, 1'b0, 25'h800000, '0,    0, 1'b1, '0,    2,  0};

    rst = 1'b1; ch_stb = '0; ch_we = '0; ch_addr = '0; ch_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_stb", 0, ram_stb, 0);
    chk("rst_ram_we", 0, ram_we, 0);
    chk("rst_ch_ack", 0, ch_ack, 0);
    chk("rst_ch_timeout", 0, ch_timeout, 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      v  = tbl[i];
      w0 = wr_seq;
      do_req(v, a, t, lat, d, ns);
      oh = 2'b01 << v.ch;
      chk("ack_vec", i, a, v.err ? 2'b00 : oh);
      chk("timeout_vec", i, t, v.err ? oh : 2'b00);
      chk("latency", i, lat, v.lat);
      chk("ram_stb_cycles", i, ns, v.nstb);
      if (!v.we && !v.err) chk("read_line", i, d, v.exp_dout);
      if (v.we) begin
        chk("write_beats", i, wr_seq - w0, 4);
        dl = v.din;
        for (int b = 0; b < 4; b++) begin
          e = {v.addr, 2'(b), dl[127-32*b -: 32]};
          chk("write_order", i*4 + b, wlog[(w0 + b) % 256], e);
        end
      end
    end

    // Both channels held: the reject above was ch0, so ch1 must win first.
    wait_req = 0;
    ch_we = '0;
    ch_addr = {25'h20, 25'h10};
    @(posedge clk); #1 ch_stb = 2'b11;
    k = 0; n = 0;
    while (k < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (ch_ack != 0) begin
        alt_ack[k] = ch_ack; alt_cyc[k] = n; alt_dout[k] = ch_dout; k++;
      end
    end
    @(posedge clk); #1 ch_stb = '0;
    chk("alt_ack_count", 0, k, 4);
    for (int i = 0; i < k; i++) begin
      chk("alt_grant", i, alt_ack[i], (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_dout", i, alt_dout[i], (i % 2 == 0) ? D1234 : PAT10);
      if (i > 0) chk("alt_spacing", i, alt_cyc[i] - alt_cyc[i-1], 6);
    end

    // RAM never acks beat 2: beat 2 starts in cycle 4, timeout 8 cycles later.
    hold_beat = 2;
    a0 = ack_cnt;
    v = '{1, 1'b0, 25'h30, '0, 0, 1'b1, '0, 12, 10};
    do_req(v, a, t, lat, d, ns);
    chk("wdog_ack", 0, a, 2'b00);
    chk("wdog_timeout", 0, t, 2'b10);
    chk("wdog_latency", 0, lat, 12);
    chk("wdog_stb_cycles", 0, ns, 10);
    chk("wdog_no_ack", 0, ack_cnt - a0, 0);
    hold_beat = -1;
    v = '{0, 1'b0, 25'h10, '0, 0, 1'b0, PAT10, 6, 4};
    do_req(v, a, t, lat, d, ns);
    chk("post_wdog_ack", 0, a, 2'b01);
    chk("post_wdog_dout", 0, d, PAT10);
    chk("post_wdog_latency", 0, lat, 6);

    // Reset while beat 1 of a write is on the bus.
    a0 = ack_cnt; t0 = to_cnt;
    @(posedge clk); #1;
    ch_addr[24:0] = 25'h50; ch_din[127:0] = DBIG; ch_we[0] = 1'b1; ch_stb[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stb_before", 0, ram_stb, 1);
    chk("mid_rst_addr_before", 0, ram_addr, {25'h50, 2'd1});
    @(posedge clk); #1 rst = 1'b0; ch_stb = '0; ch_we = '0;
    @(negedge clk);
    chk("mid_rst_stb_after", 0, ram_stb, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_ack", 0, ack_cnt - a0, 0);
    chk("mid_rst_no_timeout", 0, to_cnt - t0, 0);
    v = '{0, 1'b0, 25'h10, '0, 0, 1'b0, PAT10, 6, 4};
    do_req(v, a, t, lat, d, ns);
    chk("post_rst_ack", 0, a, 2'b01);
    chk("post_rst_dout", 0, d, PAT10);
    chk("post_rst_latency", 0, lat, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
